writeback_arbiter: RTL

- Shares the single register-file write port between NUM_REQ result producers (ALU, load unit, mul/div unit).
- Producers present {valid, rd address, data}. The arbiter grants one per cycle, round-robin.
- It drives the register-file write port from registers, one cycle after acceptance.
- It suppresses writes to x0 and counts committed writes for performance monitoring.

---
 rtl/writeback_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter that shares the register-file write port between NUM_REQ producers.
// The write port is registered; writes to x0 are accepted but never reach the register file.
module writeback_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*5-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  wb_stall,
  output logic                  reg_wr_en,
  output logic [4:0]            reg_wr_addr,
  output logic [31:0]           reg_wr_data,
  output logic [IDW-1:0]        last_grant,
  output logic [31:0]           wr_count
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic           wr_en_q, wr_en_d;
  logic [4:0]     wr_addr_q, wr_addr_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic [31:0]    wr_count_q, wr_count_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  int unsigned    scan_pos;
  logic           accept;
  logic [4:0]     sel_addr;
  logic [31:0]    sel_data;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    scan_pos    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_pos = 32'(rr_ptr_q) + i;
      if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
      cand = IDW'(scan_pos);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept    = grant_found && !wb_stall && reset_n;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_addr = req_addr[i*5 +: 5];
        sel_data = req_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_count_d   = wr_count_q;
    if (accept) begin
      rr_ptr_d     = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
      last_grant_d = grant_idx;
      // x0 destinations consume the grant but leave the write port untouched.
      if (sel_addr != 5'd0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
        if (wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      last_grant_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_count_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign last_grant  = last_grant_q;
  assign wr_count    = wr_count_q;

endmodule
